// File: rtl/alu_operand_loader_pkg.sv
// Shared constants, opcodes, loader state type and operand-requirement helper
// for the matrix ALU operand loader.
package alu_operand_loader_pkg;
    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int N_ELEM = DIM * DIM;
    localparam int FLAT_W = N_ELEM * ELEM_W;

    localparam logic [2:0] OP_CLEAR  = 3'b000;
    localparam logic [2:0] OP_SUM    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b011;
    localparam logic [2:0] OP_OPP    = 3'b100;
    localparam logic [2:0] OP_TRANS  = 3'b101;
    localparam logic [2:0] OP_SCALAR = 3'b110;
    localparam logic [2:0] OP_DET    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SAMPLE,
        ST_RESULT
    } loader_state_e;

    // Two-operand opcodes need B as well as A.
    function automatic logic needs_b(input logic [2:0] opcode);
        return opcode inside {OP_SUM, OP_SUB, OP_MUL};
    endfunction
endpackage

// File: rtl/alu_operand_loader_if.sv
// Signal bundle between the operand loader (slave) and its producer/ALU/consumer side (master).
interface alu_operand_loader_if #(
    parameter int ELEM_W = alu_operand_loader_pkg::ELEM_W,
    parameter int DIM    = alu_operand_loader_pkg::DIM
);
    // Every handshake here transfers on a rising edge where valid and ready are both high;
    // a producer keeps valid and its payload stable until that edge, ready may depend on valid.
    logic                      elem_valid;
    logic                      elem_ready;
    logic [ELEM_W-1:0]         elem_data;
    logic                      elem_sel;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [2:0]                cmd_opcode;
    logic [ELEM_W-1:0]         cmd_scalar;
    logic                      a_full;
    logic                      b_full;
    logic [DIM*DIM*ELEM_W-1:0] alu_A_flat;
    logic [DIM*DIM*ELEM_W-1:0] alu_B_flat;
    logic [ELEM_W-1:0]         alu_f;
    logic [2:0]                alu_opcode;
    logic [DIM*DIM*ELEM_W-1:0] alu_C_flat;
    logic                      alu_overflow;
    logic                      res_valid;
    logic                      res_ready;
    logic [DIM*DIM*ELEM_W-1:0] res_C_flat;
    logic                      res_overflow;

    modport slave (
        input  elem_valid, elem_data, elem_sel, cmd_valid, cmd_opcode, cmd_scalar,
               alu_C_flat, alu_overflow, res_ready,
        output elem_ready, cmd_ready, a_full, b_full, alu_A_flat, alu_B_flat,
               alu_f, alu_opcode, res_valid, res_C_flat, res_overflow
    );

    modport master (
        output elem_valid, elem_data, elem_sel, cmd_valid, cmd_opcode, cmd_scalar,
               alu_C_flat, alu_overflow, res_ready,
        input  elem_ready, cmd_ready, a_full, b_full, alu_A_flat, alu_B_flat,
               alu_f, alu_opcode, res_valid, res_C_flat, res_overflow
    );
endinterface

// File: rtl/alu_matrix_buffer.sv
// One DIMxDIM operand matrix: row-major fill via write strobe, full flag after the
// last element, synchronous clear back to empty.
module alu_matrix_buffer #(
    parameter int ELEM_W = alu_operand_loader_pkg::ELEM_W,
    parameter int DIM    = alu_operand_loader_pkg::DIM
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic                      clr,
    input  logic [ELEM_W-1:0]         wr_data,
    output logic [DIM*DIM*ELEM_W-1:0] data_flat,
    output logic                      full
);
    localparam int N_ELEM = DIM * DIM;
    localparam int IDX_W  = $clog2(N_ELEM + 1);

    logic [IDX_W-1:0] idx;

    // Writes into a full buffer are dropped, so the index stops at N_ELEM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_flat <= '0;
            idx       <= '0;
            full      <= 1'b0;
        end else if (clr) begin
            data_flat <= '0;
            idx       <= '0;
            full      <= 1'b0;
        end else if (wr_en && !full) begin
            data_flat[int'(idx)*ELEM_W +: ELEM_W] <= wr_data;
            idx <= idx + IDX_W'(1);
            if (int'(idx) == N_ELEM - 1) full <= 1'b1;
        end
    end
endmodule

// File: rtl/alu_operand_loader.sv
// Matrix ALU front end: loads A/B operands, runs one ALU operation (2-cycle latency), holds the result.
// Build option ALU_LOADER_AUTO_CLEAR_EN clears both operand buffers on the result handshake.
module alu_operand_loader #(
    parameter int ELEM_W = alu_operand_loader_pkg::ELEM_W,
    parameter int DIM    = alu_operand_loader_pkg::DIM
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    alu_operand_loader_if.slave                   bus,
    output alu_operand_loader_pkg::loader_state_e state_dbg
);
    import alu_operand_loader_pkg::*;

    localparam int FW = DIM * DIM * ELEM_W;

    loader_state_e     state_q, state_d;
    logic [2:0]        op_q;
    logic [ELEM_W-1:0] f_q;
    logic [FW-1:0]     res_c_q;
    logic              res_o_q;
    logic [FW-1:0]     a_flat, b_flat;
    logic              a_full, b_full;
    logic              elem_rdy, elem_fire, operands_ok, cmd_rdy, cmd_fire, res_fire, buf_clr;

    assign elem_rdy  = (state_q == ST_IDLE) && !(bus.elem_sel ? b_full : a_full);
    assign elem_fire = bus.elem_valid && elem_rdy;

    always_comb begin
        operands_ok = 1'b1;
        if (bus.cmd_opcode != OP_CLEAR)
            operands_ok = needs_b(bus.cmd_opcode) ? (a_full && b_full) : a_full;
    end

    // An element transfer in the same cycle takes priority over a command.
    assign cmd_rdy  = (state_q == ST_IDLE) && operands_ok && !elem_fire;
    assign cmd_fire = bus.cmd_valid && cmd_rdy;
    assign res_fire = (state_q == ST_RESULT) && bus.res_ready;

`ifdef ALU_LOADER_AUTO_CLEAR_EN
    assign buf_clr = (cmd_fire && bus.cmd_opcode == OP_CLEAR) || res_fire;
`else
    assign buf_clr = cmd_fire && bus.cmd_opcode == OP_CLEAR;
`endif

    alu_matrix_buffer #(.ELEM_W(ELEM_W), .DIM(DIM)) u_buf_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (elem_fire && !bus.elem_sel),
        .clr       (buf_clr),
        .wr_data   (bus.elem_data),
        .data_flat (a_flat),
        .full      (a_full)
    );

    alu_matrix_buffer #(.ELEM_W(ELEM_W), .DIM(DIM)) u_buf_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (elem_fire && bus.elem_sel),
        .clr       (buf_clr),
        .wr_data   (bus.elem_data),
        .data_flat (b_flat),
        .full      (b_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_fire && bus.cmd_opcode != OP_CLEAR) state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_RESULT;
            ST_RESULT: if (bus.res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The ALU's registered output from the EXEC edge is stable across SAMPLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_CLEAR;
            f_q     <= '0;
            res_c_q <= '0;
            res_o_q <= 1'b0;
        end else begin
            if (cmd_fire && bus.cmd_opcode != OP_CLEAR) begin
                op_q <= bus.cmd_opcode;
                f_q  <= bus.cmd_scalar;
            end
            if (state_q == ST_SAMPLE) begin
                res_c_q <= bus.alu_C_flat;
                res_o_q <= bus.alu_overflow;
            end
        end
    end

    assign bus.elem_ready   = elem_rdy;
    assign bus.cmd_ready    = cmd_rdy;
    assign bus.a_full       = a_full;
    assign bus.b_full       = b_full;
    assign bus.alu_A_flat   = a_flat;
    assign bus.alu_B_flat   = b_flat;
    assign bus.alu_f        = f_q;
    assign bus.alu_opcode   = (state_q == ST_EXEC || state_q == ST_SAMPLE) ? op_q : OP_CLEAR;
    assign bus.res_valid    = (state_q == ST_RESULT);
    assign bus.res_C_flat   = res_c_q;
    assign bus.res_overflow = res_o_q;
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios, a reference ALU, a spec-level model
// compared every cycle, and literal checks. Honours ALU_LOADER_AUTO_CLEAR_EN.
`timescale 1ns/1ps
module tb_alu_operand_loader;
  import alu_operand_loader_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_operand_loader_if bus ();
  loader_state_e state_dbg;

  alu_operand_loader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference ALU (the only consumer/driver of the ALU pins) ----------------
  function automatic int alu_elem(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                  input logic [7:0] f);
    int a, b, s, r;
    a = int'($signed(x));
    b = int'($signed(y));
    s = int'($signed(f));
    case (op)
      3'b000:  r = 0;
      3'b001:  r = a + b;
      3'b010:  r = a - b;
      3'b110:  r = a * s;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [FLAT_W-1:0] alu_c(input logic [2:0] op, input logic [FLAT_W-1:0] af,
                                              input logic [FLAT_W-1:0] bf, input logic [7:0] f);
    logic [FLAT_W-1:0] c;
    int r;
    c = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      r = alu_elem(op, af[k*8 +: 8], bf[k*8 +: 8], f);
      c[k*8 +: 8] = r[7:0];
    end
    return c;
  endfunction

  function automatic logic alu_o(input logic [2:0] op, input logic [FLAT_W-1:0] af,
                                 input logic [FLAT_W-1:0] bf, input logic [7:0] f);
    logic o;
    int r;
    o = 1'b0;
    for (int k = 0; k < N_ELEM; k++) begin
      r = alu_elem(op, af[k*8 +: 8], bf[k*8 +: 8], f);
      if (r > 127 || r < -128) o = 1'b1;
    end
    return o;
  endfunction

  logic [FLAT_W-1:0] alu_c_q;
  logic              alu_o_q;
  logic              force_ovf;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_c_q <= '0;
      alu_o_q <= 1'b0;
    end else begin
      alu_c_q <= alu_c(bus.alu_opcode, bus.alu_A_flat, bus.alu_B_flat, bus.alu_f);
      alu_o_q <= alu_o(bus.alu_opcode, bus.alu_A_flat, bus.alu_B_flat, bus.alu_f) | force_ovf;
    end
  end
  assign bus.alu_C_flat   = alu_c_q;
  assign bus.alu_overflow = alu_o_q;

  // ---------------- behavioural model ----------------
  logic [7:0]        ma [N_ELEM];
  logic [7:0]        mb [N_ELEM];
  int                m_acnt, m_bcnt, m_phase;   // phase: 0 idle, 1/2 ALU busy, 3 result held
  logic [2:0]        m_op;
  logic [7:0]        m_f;
  logic [FLAT_W-1:0] m_exp_c, m_res_c;
  logic              m_exp_o, m_res_o;
  logic              m_elem_rdy, m_cmd_rdy, m_ops_ok;

  function automatic logic [FLAT_W-1:0] pack(input logic [7:0] v [N_ELEM]);
    logic [FLAT_W-1:0] p;
    for (int k = 0; k < N_ELEM; k++) p[k*8 +: 8] = v[k];
    return p;
  endfunction

  always_comb begin
    m_elem_rdy = (m_phase == 0) && (bus.elem_sel ? (m_bcnt < N_ELEM) : (m_acnt < N_ELEM));
    m_ops_ok = 1'b1;
    if (bus.cmd_opcode inside {3'b001, 3'b010, 3'b011}) m_ops_ok = (m_acnt == N_ELEM) && (m_bcnt == N_ELEM);
    else if (bus.cmd_opcode != 3'b000) m_ops_ok = (m_acnt == N_ELEM);
    m_cmd_rdy = (m_phase == 0) && m_ops_ok && !(bus.elem_valid && m_elem_rdy);
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_ELEM; k++) begin ma[k] <= '0; mb[k] <= '0; end
      m_acnt <= 0; m_bcnt <= 0; m_phase <= 0;
      m_op <= '0; m_f <= '0; m_exp_c <= '0; m_exp_o <= 1'b0; m_res_c <= '0; m_res_o <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.elem_valid && m_elem_rdy) begin
            if (!bus.elem_sel) begin ma[m_acnt] <= bus.elem_data; m_acnt <= m_acnt + 1; end
            else begin mb[m_bcnt] <= bus.elem_data; m_bcnt <= m_bcnt + 1; end
          end else if (bus.cmd_valid && m_cmd_rdy) begin
            if (bus.cmd_opcode == 3'b000) begin
              for (int k = 0; k < N_ELEM; k++) begin ma[k] <= '0; mb[k] <= '0; end
              m_acnt <= 0; m_bcnt <= 0;
            end else begin
              m_op    <= bus.cmd_opcode;
              m_f     <= bus.cmd_scalar;
              m_exp_c <= alu_c(bus.cmd_opcode, pack(ma), pack(mb), bus.cmd_scalar);
              m_exp_o <= alu_o(bus.cmd_opcode, pack(ma), pack(mb), bus.cmd_scalar) | force_ovf;
              m_phase <= 1;
            end
          end
        end
        1: m_phase <= 2;
        2: begin m_phase <= 3; m_res_c <= m_exp_c; m_res_o <= m_exp_o; end
        default: if (bus.res_ready) begin
          m_phase <= 0;
`ifdef ALU_LOADER_AUTO_CLEAR_EN
          for (int k = 0; k < N_ELEM; k++) begin ma[k] <= '0; mb[k] <= '0; end
          m_acnt <= 0; m_bcnt <= 0;
`endif
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      chk("elem_ready", FLAT_W'(bus.elem_ready), FLAT_W'(m_elem_rdy));
      chk("cmd_ready", FLAT_W'(bus.cmd_ready), FLAT_W'(m_cmd_rdy));
      chk("a_full", FLAT_W'(bus.a_full), FLAT_W'(m_acnt == N_ELEM));
      chk("b_full", FLAT_W'(bus.b_full), FLAT_W'(m_bcnt == N_ELEM));
      chk("alu_A_flat", bus.alu_A_flat, pack(ma));
      chk("alu_B_flat", bus.alu_B_flat, pack(mb));
      chk("alu_opcode", FLAT_W'(bus.alu_opcode), FLAT_W'((m_phase == 1 || m_phase == 2) ? m_op : 3'b000));
      chk("alu_f", FLAT_W'(bus.alu_f), FLAT_W'(m_f));
      chk("res_valid", FLAT_W'(bus.res_valid), FLAT_W'(m_phase == 3));
      chk("res_C_flat", bus.res_C_flat, m_res_c);
      chk("res_overflow", FLAT_W'(bus.res_overflow), FLAT_W'(m_res_o));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_elem(input logic sel, input logic [7:0] d);
    bit ok;
    int t;
    ok = 1'b0; t = 0;
    bus.elem_valid = 1'b1; bus.elem_sel = sel; bus.elem_data = d;
    while (!ok && t < 50) begin
      @(negedge clock); ok = bus.elem_ready;
      @(posedge clock); #1; t++;
    end
    bus.elem_valid = 1'b0;
    chk("elem_accept", FLAT_W'(ok), FLAT_W'(1'b1));
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] s, output int waited);
    bit ok;
    ok = 1'b0; waited = 0;
    bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_scalar = s;
    while (!ok && waited < 50) begin
      @(negedge clock); ok = bus.cmd_ready;
      @(posedge clock); #1; waited++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", FLAT_W'(ok), FLAT_W'(1'b1));
  endtask

  task automatic load_a(input int base);
    for (int i = 0; i < N_ELEM; i++) send_elem(1'b0, 8'(base + i));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!bus.res_valid && lat < 20);
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clock); #1;
    bus.res_ready = 1'b0;
    chk("res_valid_drop", FLAT_W'(bus.res_valid), FLAT_W'(1'b0));
  endtask

  // ---------------- directed scenarios ----------------
  logic [FLAT_W-1:0] exp_sum, exp_scl, exp_5a;
  logic [7:0]        e24;
  int                w, lat;

  initial begin
    bus.elem_valid = 1'b0; bus.elem_sel = 1'b0; bus.elem_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 3'b001; bus.cmd_scalar = '0;
    bus.res_ready = 1'b0; force_ovf = 1'b0;
    for (int k = 0; k < N_ELEM; k++) begin
      exp_sum[k*8 +: 8] = 8'(k + 3);
      exp_scl[k*8 +: 8] = 8'(3 * (k + 1));
    end
    exp_5a = '0; exp_5a[7:0] = 8'h5A;

    // reset state
    #7;
    chk("rst_state", FLAT_W'(state_dbg), FLAT_W'(ST_IDLE));
    chk("rst_res_valid", FLAT_W'(bus.res_valid), FLAT_W'(1'b0));
    chk("rst_alu_opcode", FLAT_W'(bus.alu_opcode), FLAT_W'(3'b000));
    chk("rst_a_full", FLAT_W'(bus.a_full), FLAT_W'(1'b0));
    chk("rst_res_C", bus.res_C_flat, FLAT_W'(0));
    chk("rst_elem_ready", FLAT_W'(bus.elem_ready), FLAT_W'(1'b1));
    chk("rst_cmd_ready_op1", FLAT_W'(bus.cmd_ready), FLAT_W'(1'b0));
    bus.cmd_opcode = 3'b000; #1;
    chk("rst_cmd_ready_op0", FLAT_W'(bus.cmd_ready), FLAT_W'(1'b1));
    #4 reset_n = 1'b1;
    @(posedge clock); #1;

    // A = 1..25, B = 2s, SUM
    load_a(1);
    for (int i = 0; i < N_ELEM; i++) send_elem(1'b1, 8'd2);
    send_cmd(3'b001, 8'd0, w);
    wait_result(lat);
    chk("sum_latency", FLAT_W'(lat), FLAT_W'(2));
    chk("sum_result", bus.res_C_flat, exp_sum);
    chk("sum_ovf", FLAT_W'(bus.res_overflow), FLAT_W'(1'b0));
    take_result();

`ifdef ALU_LOADER_AUTO_CLEAR_EN
    chk("autoclr_a_full", FLAT_W'(bus.a_full), FLAT_W'(1'b0));
    chk("autoclr_b_full", FLAT_W'(bus.b_full), FLAT_W'(1'b0));
`else
    chk("keep_a_full", FLAT_W'(bus.a_full), FLAT_W'(1'b1));
    chk("keep_b_full", FLAT_W'(bus.b_full), FLAT_W'(1'b1));
    send_cmd(3'b001, 8'd0, w);
    chk("repeat_immediate", FLAT_W'(w), FLAT_W'(1));
    wait_result(lat);
    chk("repeat_result", bus.res_C_flat, exp_sum);
    take_result();
`endif

    // SCALAR with overflow forced, B only partially loaded, result held 5 cycles
    send_cmd(3'b000, 8'd0, w);
    load_a(1);
    for (int i = 0; i < 3; i++) send_elem(1'b1, 8'd7);
    force_ovf = 1'b1;
    send_cmd(3'b110, 8'd3, w);
    chk("scalar_with_partial_b", FLAT_W'(w), FLAT_W'(1));
    wait_result(lat);
    chk("scalar_latency", FLAT_W'(lat), FLAT_W'(2));
    chk("scalar_ovf", FLAT_W'(bus.res_overflow), FLAT_W'(1'b1));
    e24 = bus.res_C_flat[199:192];
    chk("scalar_elem24", FLAT_W'(e24), FLAT_W'(8'd75));
    bus.elem_valid = 1'b1; bus.elem_sel = 1'b1; bus.elem_data = 8'd9;
    repeat (5) begin
      @(negedge clock);
      chk("hold_res_valid", FLAT_W'(bus.res_valid), FLAT_W'(1'b1));
      chk("hold_elem_ready", FLAT_W'(bus.elem_ready), FLAT_W'(1'b0));
      chk("hold_res_C", bus.res_C_flat, exp_scl);
    end
    @(posedge clock); #1;
    bus.elem_valid = 1'b0;
    take_result();
    force_ovf = 1'b0;

    // 26th element refused, then clear, next element lands at [7:0]
    send_cmd(3'b000, 8'd0, w);
    load_a(10);
    bus.elem_valid = 1'b1; bus.elem_sel = 1'b0; bus.elem_data = 8'd99;
    repeat (2) begin
      @(negedge clock);
      chk("full_a_refuses", FLAT_W'(bus.elem_ready), FLAT_W'(1'b0));
    end
    @(posedge clock); #1;
    bus.elem_valid = 1'b0;
    send_cmd(3'b000, 8'd0, w);
    chk("clr_a_full", FLAT_W'(bus.a_full), FLAT_W'(1'b0));
    chk("clr_a_flat", bus.alu_A_flat, FLAT_W'(0));
    send_elem(1'b0, 8'h5A);
    chk("after_clr_first", bus.alu_A_flat, exp_5a);

    // SUM waits for B, accepted the cycle after the last B element
    send_cmd(3'b000, 8'd0, w);
    load_a(1);
    bus.cmd_opcode = 3'b001; bus.cmd_scalar = 8'd0; bus.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("sum_blocked", FLAT_W'(bus.cmd_ready), FLAT_W'(1'b0));
    end
    @(posedge clock); #1;
    for (int i = 0; i < N_ELEM; i++) send_elem(1'b1, 8'd2);
    @(negedge clock);
    chk("cmd_after_last_b", FLAT_W'(bus.cmd_ready), FLAT_W'(1'b1));
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    chk("exec_after_accept", FLAT_W'(state_dbg), FLAT_W'(ST_EXEC));
    wait_result(lat);
    chk("sum2_result", bus.res_C_flat, exp_sum);
    take_result();

    // reset during SAMPLE
    send_cmd(3'b000, 8'd0, w);
    load_a(1);
    send_cmd(3'b100, 8'd0, w);
    @(posedge clock); #1;
    chk("in_sample", FLAT_W'(state_dbg), FLAT_W'(ST_SAMPLE));
    reset_n = 1'b0; #1;
    chk("midrst_res_valid", FLAT_W'(bus.res_valid), FLAT_W'(1'b0));
    chk("midrst_alu_opcode", FLAT_W'(bus.alu_opcode), FLAT_W'(3'b000));
    chk("midrst_a_full", FLAT_W'(bus.a_full), FLAT_W'(1'b0));
    chk("midrst_a_flat", bus.alu_A_flat, FLAT_W'(0));
    @(negedge clock); #2;
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      chk("no_result_after_rst", FLAT_W'(bus.res_valid), FLAT_W'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
